// File: rtl/client_rq_ack_q_if.sv
// Referee request/acknowledge channel between one bus client and the referee.
// The client drives the request side (master); the referee drives the
// acknowledge side (slave).
interface client_rq_ack_q_if #(
    parameter int REQ_DATA_WIDTH = 8,
    parameter int ACK_DATA_WIDTH = 8
) ();

    logic                      client_req;
    logic [REQ_DATA_WIDTH-1:0] client_data_req;
    logic                      client_ack;
    logic [ACK_DATA_WIDTH-1:0] client_data_ack;

    modport master (
        output client_req,
        output client_data_req,
        input  client_ack,
        input  client_data_ack
    );

    modport slave (
        input  client_req,
        input  client_data_req,
        output client_ack,
        output client_data_ack
    );

endinterface

// File: rtl/client_rq_ack_q.sv
// Bus client for the req/ack referee protocol.
//
// Local requests are queued in a FIFO_DEPTH-entry FIFO and issued one at a
// time on the referee channel. The client index occupies the MSBs of every
// request word. The head entry stays in the FIFO while it is in flight and is
// popped when the referee acknowledges it. A request that is not acknowledged
// within TIMEOUT cycles is abandoned with a one-cycle timeout_err pulse.
//
// Every request ends with exactly one GAP cycle (client_req low) before the
// next one can start.
//
// Build option: define CLIENT_RETRY_EN to keep the head entry on timeout, so
// the same request is reissued after the GAP cycle. When it is not defined,
// the timed-out head is discarded.
module client_rq_ack_q #(
    parameter int CLIENT_IDX     = 0,
    parameter int IDX_WIDTH      = 1,
    parameter int REQ_DATA_WIDTH = 8,
    parameter int ACK_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,

    // Local request side
    input  logic                                push,
    input  logic [REQ_DATA_WIDTH-IDX_WIDTH-1:0] push_data,
    output logic                                full,
    output logic                                overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     level,

    // Referee channel
    client_rq_ack_q_if.master                   bus,

    // Local response side
    output logic                                rsp_valid,
    output logic [ACK_DATA_WIDTH-1:0]           rsp_data,
    output logic                                timeout_err
);

    localparam int PAY_W = REQ_DATA_WIDTH - IDX_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [IDX_WIDTH-1:0] IDX_FIELD = IDX_WIDTH'(CLIENT_IDX);
    localparam logic [LVL_W-1:0]     LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Request queue
    logic [PAY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;

    // Cycles spent in the current REQ interval, minus one
    logic [CNT_W-1:0] tmo_cnt_q;

    // Registered outputs
    logic                      req_q;
    logic [REQ_DATA_WIDTH-1:0] data_req_q;
    logic                      overflow_q;
    logic                      rsp_valid_q;
    logic [ACK_DATA_WIDTH-1:0] rsp_data_q;
    logic                      timeout_err_q;

    // Per-cycle events
    logic push_ok;
    logic ack_hit;
    logic tmo_hit;
    logic pop;

    // full is derived from the pre-pop level, so a push that coincides with
    // a pop while the queue is full is still dropped.
    assign full    = (level_q == LVL_FULL);
    assign push_ok = push && !full;

    // An ack only counts while a request is on the bus.
    assign ack_hit = (state_q == S_REQ) && bus.client_ack;

    // The ack wins over a timeout that expires in the same cycle.
    assign tmo_hit = (state_q == S_REQ) && !bus.client_ack && (tmo_cnt_q == CNT_LAST);

`ifdef CLIENT_RETRY_EN
    // A timed-out head stays queued and is reissued after the GAP cycle.
    assign pop = ack_hit;
`else
    // A timed-out head is discarded along with its request.
    assign pop = ack_hit || tmo_hit;
`endif

    // Next-state logic for the request sequencer.
    // NOTE: every variable assigned in an always_comb gets a default first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_hit || tmo_hit) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = (level_q != '0) ? S_REQ : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Timeout counter: held at zero outside REQ, so it starts from zero on
    // every entry to REQ, and counts each REQ cycle that ends without an exit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q != S_REQ) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end

    // Queue storage: written on an accepted push.
    // NOTE: the storage array is deliberately not reset; an entry is only
    // read once level shows it as valid, so clearing the pointers and the
    // level is enough to empty the queue.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Request channel outputs. They are registered from the next state, so
    // client_req is high exactly while the sequencer sits in REQ. The head
    // cannot change during REQ: pops only happen on the cycle REQ is left,
    // and a full queue never overwrites the head slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q      <= 1'b0;
            data_req_q <= '0;
        end else begin
            req_q      <= (state_d == S_REQ);
            data_req_q <= (state_d == S_REQ) ? {IDX_FIELD, mem[rd_ptr_q]} : '0;
        end
    end

    // Local status pulses and captured acknowledge data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            overflow_q    <= push && full;
            rsp_valid_q   <= ack_hit;
            timeout_err_q <= tmo_hit;
            if (ack_hit) begin
                rsp_data_q <= bus.client_data_ack;
            end
        end
    end

    assign level               = level_q;
    assign overflow            = overflow_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_data            = rsp_data_q;
    assign timeout_err         = timeout_err_q;
    assign bus.client_req      = req_q;
    assign bus.client_data_req = data_req_q;

endmodule

// File: tb/tb_client_rq_ack_q.sv
// Self-checking bench for client_rq_ack_q.
// Directed scenarios followed by random traffic. Every cycle is compared
// against a queue-based reference model of the client's behaviour.
module tb_client_rq_ack_q;

    localparam int CLIENT_IDX = 1;
    localparam int IDX_WIDTH  = 1;
    localparam int REQ_W      = 8;
    localparam int ACK_W      = 8;
    localparam int DEPTH      = 4;
    localparam int TMO        = 16;
    localparam int PAY_W      = REQ_W - IDX_WIDTH;
    localparam int LVL_W      = $clog2(DEPTH + 1);

    localparam logic [IDX_WIDTH-1:0] IDX_F = 1'b1;

`ifdef CLIENT_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             push;
    logic [PAY_W-1:0] push_data;
    logic             full;
    logic             overflow;
    logic [LVL_W-1:0] level;
    logic             rsp_valid;
    logic [ACK_W-1:0] rsp_data;
    logic             timeout_err;

    client_rq_ack_q_if #(.REQ_DATA_WIDTH(REQ_W), .ACK_DATA_WIDTH(ACK_W)) bus ();

    client_rq_ack_q #(
        .CLIENT_IDX    (CLIENT_IDX),
        .IDX_WIDTH     (IDX_WIDTH),
        .REQ_DATA_WIDTH(REQ_W),
        .ACK_DATA_WIDTH(ACK_W),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT       (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_data),
        .full       (full),
        .overflow   (overflow),
        .level      (level),
        .bus        (bus.master),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the queue holds every accepted payload, head first,
    // including the one on the bus. m_busy says a request is on the bus and
    // m_waited counts the edges it has been seen there.
    logic [PAY_W-1:0] m_q[$];
    bit               m_busy    = 1'b0;
    int               m_waited  = 0;
    logic [REQ_W-1:0] m_data_req = '0;
    bit               m_ovf     = 1'b0;
    bit               m_rspv    = 1'b0;
    bit               m_terr    = 1'b0;
    logic [ACK_W-1:0] m_rspd    = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled at it.
    task automatic model_step(input logic r, input logic p, input logic [PAY_W-1:0] pd,
                              input logic a, input logic [ACK_W-1:0] ad);
        int n_pre;
        bit full_pre;
        bit was_busy;
        bit ended;
        if (!r) begin
            m_q.delete();
            m_busy     = 1'b0;
            m_waited   = 0;
            m_data_req = '0;
            m_ovf      = 1'b0;
            m_rspv     = 1'b0;
            m_terr     = 1'b0;
            m_rspd     = '0;
            return;
        end
        n_pre    = m_q.size();
        full_pre = (n_pre == DEPTH);
        m_ovf    = p && full_pre;
        m_rspv   = 1'b0;
        m_terr   = 1'b0;
        ended    = 1'b0;
        was_busy = m_busy;
        if (was_busy) begin
            m_waited++;
            if (a) begin
                m_rspv = 1'b1;
                m_rspd = ad;
                void'(m_q.pop_front());
                ended = 1'b1;
            end else if (m_waited == TMO) begin
                m_terr = 1'b1;
                if (!RETRY) void'(m_q.pop_front());
                ended = 1'b1;
            end
        end
        if (!was_busy && n_pre > 0) begin
            m_busy     = 1'b1;
            m_waited   = 0;
            m_data_req = {IDX_F, m_q[0]};
        end else if (ended) begin
            m_busy     = 1'b0;
            m_data_req = '0;
        end
        if (p && !full_pre) m_q.push_back(pd);
    endtask

    // One clock cycle: drive on the falling edge, sample 1 time unit after
    // the rising edge, and compare every output with the model.
    task automatic cycle(input logic r, input logic p, input logic [PAY_W-1:0] pd,
                         input logic a, input logic [ACK_W-1:0] ad);
        @(negedge clk);
        rst_n               = r;
        push                = p;
        push_data           = pd;
        bus.client_ack      = a;
        bus.client_data_ack = ad;
        @(posedge clk);
        #1;
        model_step(r, p, pd, a, ad);
        check("client_req",      bus.client_req,      m_busy);
        check("client_data_req", bus.client_data_req, m_data_req);
        check("level",           level,               m_q.size());
        check("full",            full,                m_q.size() == DEPTH);
        check("overflow",        overflow,            m_ovf);
        check("rsp_valid",       rsp_valid,           m_rspv);
        check("rsp_data",        rsp_data,            m_rspd);
        check("timeout_err",     timeout_err,         m_terr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        int hi_cnt;
        int terr_cnt;
        int rsp_cnt;
        bit seen;

        rst_n               = 1'b0;
        push                = 1'b0;
        push_data           = '0;
        bus.client_ack      = 1'b0;
        bus.client_data_ack = '0;

        // Reset state
        cycle(1'b0, 1'b0, '0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0, 1'b0, '0);
        check("rst_req",   bus.client_req, 0);
        check("rst_level", level,          0);
        check("rst_rsp",   rsp_data,       0);

        // Single transaction, ack in the third REQ cycle
        cycle(1'b1, 1'b1, 7'h15, 1'b0, '0);
        check("sgl_level1", level, 1);
        idle(1);
        check("sgl_data_c1", bus.client_data_req, 32'h95);
        idle(2);
        check("sgl_data_c3", bus.client_data_req, 32'h95);
        cycle(1'b1, 1'b0, '0, 1'b1, 8'hA5);
        check("sgl_rsp_valid", rsp_valid,      1);
        check("sgl_rsp_data",  rsp_data,       32'hA5);
        check("sgl_level0",    level,          0);
        check("sgl_req_low",   bus.client_req, 0);
        idle(2);

        // Back-to-back: fill, then ack every request in its first cycle
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, PAY_W'(i), 1'b0, '0);
        check("b2b_full", full, 1);
        rsp_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b1, ACK_W'(8'hC0 + i));
            if (rsp_valid === 1'b1) rsp_cnt++;
        end
        check("b2b_rsp_count", rsp_cnt, 4);
        idle(2);

        // Overflow: five pushes into a four-entry queue
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, PAY_W'(7'h10 + i), 1'b0, '0);
        check("ovf_pulse", overflow, 1);
        check("ovf_level", level,    4);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b1, 8'h3C);
            if (bus.client_data_req === {IDX_F, 7'h14}) seen = 1'b1;
        end
        check("ovf_5th_issued", seen, 0);
        idle(2);

        // Timeout: never ack
        cycle(1'b1, 1'b1, 7'h2A, 1'b0, '0);
        hi_cnt   = 0;
        terr_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b0, '0);
            if (bus.client_req === 1'b1) hi_cnt++;
            if (timeout_err === 1'b1) terr_cnt++;
        end
        check("tmo_req_cycles", hi_cnt,      TMO);
        check("tmo_err_count",  terr_cnt,    1);
        check("tmo_err_edge",   timeout_err, 1);
        idle(1);
        check("tmo_reissue",    bus.client_req, RETRY);
        check("tmo_level",      level,          RETRY);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b1, 8'h11);
        idle(2);

        // Ack in the 16th REQ cycle beats the timeout
        cycle(1'b1, 1'b1, 7'h33, 1'b0, '0);
        idle(16);
        cycle(1'b1, 1'b0, '0, 1'b1, 8'h5C);
        check("ackto_rsp_valid", rsp_valid,   1);
        check("ackto_rsp_data",  rsp_data,    32'h5C);
        check("ackto_no_tmo",    timeout_err, 0);
        idle(2);

        // Reset during REQ with three entries queued
        for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b1, PAY_W'(7'h40 + i), 1'b0, '0);
        idle(1);
        cycle(1'b0, 1'b0, '0, 1'b0, '0);
        check("rstm_req",   bus.client_req,      0);
        check("rstm_data",  bus.client_data_req, 0);
        check("rstm_level", level,               0);
        rsp_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b0, '0);
            if (rsp_valid === 1'b1 || timeout_err === 1'b1) rsp_cnt++;
        end
        check("rstm_silent", rsp_cnt, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 99) < 45),
                  PAY_W'($urandom),
                  ($urandom_range(0, 99) < 25),
                  ACK_W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
